rc4_encrypt_fsm: RTL
====================

Name: rc4_encrypt_fsm

Overview:
- Produces RC4 ciphertext from a plaintext message. This is the transmit-side counterpart of the decryption state machine.
- Assumes S-memory was already initialised and key-scheduled upstream.
- Runs the PRGA over the shared 256x8 S RAM: increment i, accumulate j, swap, read keystream.
- Reads plaintext bytes from a message memory, XORs each with the keystream, and writes ciphertext to a result RAM.

Parameters:
- MSG_LEN, 32: number of message bytes processed per run (1..2**MSG_AW).
- MSG_AW, 5: address width of the plaintext and ciphertext memories.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- s_rddata  input  8  S RAM read data
- s_address  output  8  S RAM address
- s_wrdata  output  8  S RAM write data
- s_wren  output  1  S RAM write enable
- plaintext_in  input  8  plaintext memory read data
- pt_address  output  MSG_AW  plaintext memory address
- ct_address  output  MSG_AW  ciphertext RAM address
- ct_data  output  8  ciphertext RAM write data
- ct_wren  output  1  ciphertext RAM write enable
- busy  output  1  high from CLEAR through NEXT_K
- done  output  1  high while in DONE
- error  output  1  sticky plaintext-check failure (optional feature)

Behaviour:
- Reset (reset_n low, asynchronous):
  - Go to IDLE.
  - Clear i, j, k, si, sj, f, p and all outputs to 0.
  - Reset mid-run abandons the run. S RAM and ciphertext RAM contents are then undefined.
- Memory timing:
  - All memories are synchronous-read.
  - The FSM holds each read address for 3 consecutive states (drive, wait, latch).
  - Data is sampled at the end of the latch state.
- IDLE: start -> CLEAR; otherwise stay.
- CLEAR: i<=0, j<=0, k<=0 -> INC_I.
- Per-byte sequence, 14 cycles:
  - INC_I: i<=i+1 (mod 256).
  - RD_SI, WT_SI: s_address=i.
  - LT_SI: s_address=i; si<=s_rddata; j<=j+s_rddata (mod 256).
  - RD_SJ, WT_SJ, LT_SJ: s_address=j. In LT_SJ, sj<=s_rddata.
  - WR_SJ: s_address=j, s_wrdata=si, s_wren=1.
  - WR_SI: s_address=i, s_wrdata=sj, s_wren=1.
  - RD_F, WT_F: s_address=si+sj (mod 256); pt_address=k.
  - LT_F: same addresses; f<=s_rddata; p<=plaintext_in.
  - WR_CT: ct_address=k, ct_data=f^p, ct_wren=1.
  - NEXT_K: if k==MSG_LEN-1 -> DONE; else k<=k+1 -> INC_I.
- Total latency: done rises 1+14*MSG_LEN cycles after start is sampled (449 for MSG_LEN=32).
- DONE:
  - done=1, held until start.
  - start -> CLEAR. A new message continues on the current S contents; S is not re-initialised.
- Outputs outside active states:
  - s_wren and ct_wren are 0 in every state other than WR_SJ/WR_SI and WR_CT respectively.
  - Address outputs are 0 in IDLE/DONE.
- Boundary conditions:
  - start while busy is ignored.
  - When i==j, the swap writes the same location twice with the same value. This is legal and gives a consistent result.
  - i, j and si+sj wrap mod 256; k never exceeds MSG_LEN-1.

Optional Feature:
- Macro: RC4_PLAINTEXT_CHECK_EN.
- Defined:
  - In LT_F, p is checked against 'a'..'z' (0x61..0x7A) or space (0x20).
  - On failure the FSM skips WR_CT for that byte, sets error=1 and goes to DONE.
  - error clears on CLEAR or on reset.
- Undefined: error is tied to 0 and all bytes are encrypted unconditionally.

Decomposition:
- Package rc4_pkg holds:
  - The state enum.
  - The ASCII_SPACE, ASCII_A_LOW and ASCII_Z_LOW constants.
  - A function is_valid_char(byte).
- No sub-module: the k counter and datapath registers are inline.

Test Plan:
- Identity S (S[x]=x), plaintext all 0x00, MSG_LEN=2 -> ct[0]=0x02, ct[1]=0x05. After the run, S[2]=0x03 and S[3]=0x02.
- Identity S, plaintext[0]=0x61 ('a') -> ct[0]=0x63.
- S preloaded from the KSA reference model with key "Key", plaintext "Plaintext", MSG_LEN=9 -> ciphertext BB F3 16 E8 D9 40 AF 0A D3.
- MSG_LEN=32, start pulse -> done high exactly 449 cycles later. Exactly 32 ct_wren pulses and 64 s_wren pulses are observed.
- Extra start pulses mid-run -> no effect on the cycle count or outputs. reset_n low at byte 10 -> all outputs 0 in the same cycle, IDLE on release, and a new start behaves as a fresh run.
- With RC4_PLAINTEXT_CHECK_EN, plaintext[3]=0x41 ('A') -> ct[0..2] written, no ct write at address 3, error=1 and done=1. A subsequent start clears error.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 encryption controller.
package rc4_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INC_I,
        ST_RD_SI,
        ST_WT_SI,
        ST_LT_SI,
        ST_RD_SJ,
        ST_WT_SJ,
        ST_LT_SJ,
        ST_WR_SJ,
        ST_WR_SI,
        ST_RD_F,
        ST_WT_F,
        ST_LT_F,
        ST_WR_CT,
        ST_NEXT_K,
        ST_DONE
    } rc4_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_A_LOW = 8'h61;
    localparam logic [7:0] ASCII_Z_LOW = 8'h7A;

    function automatic logic is_valid_char(input logic [7:0] c);
        return (c == ASCII_SPACE) || ((c >= ASCII_A_LOW) && (c <= ASCII_Z_LOW));
    endfunction

endpackage

// File: rtl/rc4_encrypt_fsm.sv
// RC4 PRGA encryption controller over a shared S RAM, message memory and ciphertext RAM.
// Optional plaintext check enabled by defining RC4_PLAINTEXT_CHECK_EN.
//
// state     | meaning
// IDLE      | waiting for start
// CLEAR     | reset i, j, k (and error) for a new message
// INC_I     | i <= i+1
// RD/WT/LT_SI | read S[i], accumulate j
// RD/WT/LT_SJ | read S[j]
// WR_SJ     | S[j] <= si
// WR_SI     | S[i] <= sj
// RD/WT/LT_F  | read keystream S[si+sj] and plaintext[k]
// WR_CT     | ciphertext[k] <= f ^ p
// NEXT_K    | advance k or finish
// DONE      | message complete, waiting for start
module rc4_encrypt_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_address,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    input  logic [7:0]        plaintext_in,
    output logic [MSG_AW-1:0] pt_address,
    output logic [MSG_AW-1:0] ct_address,
    output logic [7:0]        ct_data,
    output logic              ct_wren,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    rc4_state_e        state;
    logic [7:0]        i, j, si, sj, f, p;
    logic [MSG_AW-1:0] k;

    // f and p are only meaningful while the write strobe is up
    assign ct_data = ct_wren ? (f ^ p) : 8'h00;

`ifndef RC4_PLAINTEXT_CHECK_EN
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            si         <= '0;
            sj         <= '0;
            f          <= '0;
            p          <= '0;
            s_address  <= '0;
            s_wrdata   <= '0;
            s_wren     <= 1'b0;
            pt_address <= '0;
            ct_address <= '0;
            ct_wren    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef RC4_PLAINTEXT_CHECK_EN
            error      <= 1'b0;
`endif
        end else begin
            s_wren  <= 1'b0;
            ct_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
`ifdef RC4_PLAINTEXT_CHECK_EN
                    error <= 1'b0;
`endif
                    state <= ST_INC_I;
                end
                ST_INC_I: begin
                    i         <= i + 8'd1;
                    s_address <= i + 8'd1;
                    state     <= ST_RD_SI;
                end
                ST_RD_SI: state <= ST_WT_SI;
                ST_WT_SI: state <= ST_LT_SI;
                ST_LT_SI: begin
                    si        <= s_rddata;
                    j         <= j + s_rddata;
                    s_address <= j + s_rddata;
                    state     <= ST_RD_SJ;
                end
                ST_RD_SJ: state <= ST_WT_SJ;
                ST_WT_SJ: state <= ST_LT_SJ;
                ST_LT_SJ: begin
                    sj       <= s_rddata;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                    state    <= ST_WR_SJ;
                end
                ST_WR_SJ: begin
                    s_address <= i;
                    s_wrdata  <= sj;
                    s_wren    <= 1'b1;
                    state     <= ST_WR_SI;
                end
                ST_WR_SI: begin
                    s_address  <= si + sj;
                    s_wrdata   <= '0;
                    pt_address <= k;
                    state      <= ST_RD_F;
                end
                ST_RD_F: state <= ST_WT_F;
                ST_WT_F: state <= ST_LT_F;
                ST_LT_F: begin
                    f          <= s_rddata;
                    p          <= plaintext_in;
                    s_address  <= '0;
                    pt_address <= '0;
`ifdef RC4_PLAINTEXT_CHECK_EN
                    if (!is_valid_char(plaintext_in)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        ct_address <= k;
                        ct_wren    <= 1'b1;
                        state      <= ST_WR_CT;
                    end
`else
                    ct_address <= k;
                    ct_wren    <= 1'b1;
                    state      <= ST_WR_CT;
`endif
                end
                ST_WR_CT: begin
                    ct_address <= '0;
                    state      <= ST_NEXT_K;
                end
                ST_NEXT_K: begin
                    if (k == K_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        k     <= k + MSG_AW'(1);
                        state <= ST_INC_I;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_CLEAR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
